// File: rtl/rf_dump_pkg.sv
// Shared definitions for the register-file dump reader and the register file
// it sits beside: default widths and the dump FSM state encoding.
package rf_dump_pkg;

  // Default register index and data widths, shared with regfile.
  localparam int RF_AW    = 3;
  localparam int RF_WIDTH = 16;

  // Dump sequencer states (2-bit encoding).
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2,
    S_FIN  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Sequential reader for the register file. A start pulse walks the read
// index from 0 to NREG-1, captures the combinational regfile output for each
// register and presents it on a valid/ready stream tagged with its index.
// The register file is only read, never written.
module regfile_dump
  import rf_dump_pkg::*;
#(
  parameter int NREG  = 8,
  parameter int AW    = RF_AW,
  parameter int WIDTH = RF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  output logic [AW-1:0]    readnum_o,
  input  logic [WIDTH-1:0] rf_data_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [AW-1:0]    dout_idx_o,
  output logic             dout_valid_o,
  input  logic             dout_ready_i,
  output logic             busy_o,
  output logic             done_o
);

  // Index of the last register walked; NREG is a power of two no larger
  // than 2**AW, so this always fits in AW bits and idx never wraps.
  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  dump_state_t      state_q;
  logic [AW-1:0]    idx_q;
  logic [WIDTH-1:0] dout_q;
  logic [AW-1:0]    dout_idx_q;
  logic             dout_valid_q;
  logic             done_q;

  // Dump sequencer: state, index counter and all registered stream outputs.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking '=' would let later lines see
  // already-updated state and silently reorder the pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      dout_q       <= '0;
      dout_idx_q   <= '0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            idx_q   <= '0;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          // readnum has been stable for a full cycle: take the snapshot.
          dout_q       <= rf_data_i;
          dout_idx_q   <= idx_q;
          dout_valid_q <= 1'b1;
          state_q      <= S_HOLD;
        end
        S_HOLD: begin
          // Word is held unchanged until the consumer takes it.
          if (dout_ready_i) begin
            dout_valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              idx_q   <= idx_q + AW'(1);
              state_q <= S_READ;
            end
          end
        end
        S_FIN: begin
          // Park the read port back on register 0 for IDLE.
          idx_q   <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers or from the state alone, so there
  // is no combinational path from dout_ready to dout_valid.
  assign readnum_o    = idx_q;
  assign dout_o       = dout_q;
  assign dout_idx_o   = dout_idx_q;
  assign dout_valid_o = dout_valid_q;
  assign done_o       = done_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump. A small register-file array in the
// bench feeds rf_data from readnum. A word-count reference model predicts
// every output each cycle; directed scenarios add literal expectations, and
// a randomized phase mixes backpressure, stray starts and regfile writes.
module tb_regfile_dump;

  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int W    = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_i = 1'b0;
  logic          dout_ready_i = 1'b0;
  logic [AW-1:0] readnum_o;
  logic [W-1:0]  rf_data_i;
  logic [W-1:0]  dout_o;
  logic [AW-1:0] dout_idx_o;
  logic          dout_valid_o;
  logic          busy_o;
  logic          done_o;

  // Bench-side register file; written only at negedges.
  logic [W-1:0] rf [NREG];
  assign rf_data_i = rf[readnum_o];

  regfile_dump #(.NREG(NREG), .AW(AW), .WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .readnum_o    (readnum_o),
    .rf_data_i    (rf_data_i),
    .dout_o       (dout_o),
    .dout_idx_o   (dout_idx_o),
    .dout_valid_o (dout_valid_o),
    .dout_ready_i (dout_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks a dump as "words delivered so far" plus whether a
  // word is currently offered, rather than as named states.
  bit            m_busy, m_valid, m_done;
  int            m_cnt;
  logic [W-1:0]  m_dout;
  logic [AW-1:0] m_idx;

  // Previous-cycle DUT outputs, used to log transfers.
  bit            p_valid, p_busy;
  logic [W-1:0]  p_dout;
  logic [AW-1:0] p_idx;

  int cyc = 0, start_edge = 0, done_edge = 0, busy_rise_edge = 0, n_done = 0;
  logic [W-1:0]  got_data[$];
  logic [AW-1:0] got_idx[$];

  // Model step at each edge, then compare all outputs 1ns later.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_busy = 0; m_valid = 0; m_done = 0; m_cnt = 0; m_dout = '0; m_idx = '0;
    end else begin
      if (p_valid && dout_ready_i) begin
        got_data.push_back(p_dout);
        got_idx.push_back(p_idx);
      end
      if (m_done) begin
        m_done = 0;
        m_busy = 0;
      end else if (!m_busy) begin
        if (start_i) begin
          m_busy = 1; m_cnt = 0; start_edge = cyc;
        end
      end else if (m_valid) begin
        if (dout_ready_i) begin
          m_valid = 0;
          m_cnt++;
          if (m_cnt == NREG) m_done = 1;
        end
      end else begin
        // Snapshot of the register as it stands at this edge.
        m_valid = 1;
        m_idx   = AW'(m_cnt);
        m_dout  = rf[m_cnt];
      end
    end
    #1;
    check("dout_valid", dout_valid_o, m_valid);
    check("busy", busy_o, m_busy);
    check("done", done_o, m_done);
    check("dout", dout_o, m_dout);
    check("dout_idx", dout_idx_o, m_idx);
    if (!m_done) check("readnum", readnum_o, m_busy ? m_cnt : 0);
    if (done_o) begin
      n_done++;
      done_edge = cyc;
    end
    if (busy_o && !p_busy) busy_rise_edge = cyc;
    p_valid = dout_valid_o;
    p_busy  = busy_o;
    p_dout  = dout_o;
    p_idx   = dout_idx_o;
  end

  task automatic preload();
    rf[0] = 16'h0000; rf[1] = 16'h0001; rf[2] = 16'h0002; rf[3] = 16'h0003;
    rf[4] = 16'h0004; rf[5] = 16'h0011; rf[6] = 16'h0040; rf[7] = 16'hFFFF;
  endtask

  task automatic pulse_start();
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
  endtask

  task automatic wait_word(input int idx);
    bit found = 0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clk);
      found = dout_valid_o && (dout_idx_o == AW'(idx));
    end
    check("timeout_word", found, 1);
  endtask

  task automatic wait_done();
    int d0 = n_done;
    for (int t = 0; t < 200 && n_done == d0; t++) @(negedge clk);
    check("timeout_done", n_done > d0, 1);
  endtask

  task automatic clear_log();
    got_data.delete();
    got_idx.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int gap;
    preload();
    // Asynchronous reset: outputs must clear without a clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst_valid", dout_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_readnum", readnum_o, 0);
    check("rst_dout", dout_o, 0);
    check("rst_dout_idx", dout_idx_o, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: full dump with ready held high.
    dout_ready_i = 1'b1;
    clear_log();
    pulse_start();
    wait_done();
    // done is visible after edge k+16, i.e. in the cycle ending at edge k+17.
    check("t1_done_latency", done_edge - start_edge, 16);
    check("t1_count", got_data.size(), 8);
    if (got_data.size() == 8) begin
      check("t1_w0", got_data[0], 16'h0000);
      check("t1_w5", got_data[5], 16'h0011);
      check("t1_w6", got_data[6], 16'h0040);
      check("t1_w7", got_data[7], 16'hFFFF);
      for (int i = 0; i < 8; i++) check("t1_idx", got_idx[i], i);
    end
    @(negedge clk);
    check("t1_busy_after", busy_o, 0);

    // 2: backpressure for 3 cycles on word 2.
    clear_log();
    pulse_start();
    wait_word(2);
    dout_ready_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t2_hold_valid", dout_valid_o, 1);
      check("t2_hold_dout", dout_o, 16'h0002);
      check("t2_hold_idx", dout_idx_o, 2);
    end
    dout_ready_i = 1'b1;
    wait_done();
    check("t2_count", got_data.size(), 8);
    if (got_data.size() == 8) check("t2_w2", got_data[2], 16'h0002);

    // 3: regfile writes during a dump.
    clear_log();
    pulse_start();
    wait_word(1);
    rf[5] = 16'h0022;
    rf[0] = 16'h1234;
    wait_done();
    check("t3_count", got_data.size(), 8);
    if (got_data.size() == 8) begin
      check("t3_w5_new", got_data[5], 16'h0022);
      check("t3_w0_old", got_data[0], 16'h0000);
    end
    @(negedge clk) preload();

    // 4: start while busy is ignored.
    clear_log();
    d0 = n_done;
    pulse_start();
    wait_word(4);
    start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    wait_done();
    repeat (6) @(negedge clk);
    check("t4_count", got_data.size(), 8);
    check("t4_done_pulses", n_done - d0, 1);

    // 5: reset while holding word 3, then a fresh dump.
    pulse_start();
    wait_word(3);
    dout_ready_i = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_rst_valid", dout_valid_o, 0);
    check("t5_rst_busy", busy_o, 0);
    check("t5_rst_dout", dout_o, 0);
    @(negedge clk);
    reset = 1'b0;
    dout_ready_i = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_no_resume", busy_o, 0);
    clear_log();
    pulse_start();
    wait_done();
    check("t5_count", got_data.size(), 8);
    if (got_data.size() == 8) check("t5_first_idx", got_idx[0], 0);

    // 6: start held high gives back-to-back dumps.
    clear_log();
    @(negedge clk) start_i = 1'b1;
    wait_done();
    gap = done_edge;
    for (int t = 0; t < 20 && busy_rise_edge <= gap; t++) @(negedge clk);
    check("t6_restart_gap", busy_rise_edge - gap, 2);
    wait_done();
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_count", got_data.size(), 16);
    if (got_data.size() == 16) check("t6_second_first_idx", got_idx[8], 0);

    // 7: randomized backpressure, stray starts and regfile writes.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      dout_ready_i = ($urandom_range(0, 3) != 0);
      start_i      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, NREG - 1)] = W'($urandom);
    end
    start_i = 1'b0;
    dout_ready_i = 1'b1;
    for (int t = 0; t < 100 && busy_o; t++) @(negedge clk);
    check("t7_drained", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
